// File: rtl/ndma_read_mgr_if.sv
// OBI_BUS -- read-capable OBI A/R channel bundle.
//   A channel : req, gnt, addr, we, be, wdata, aid, a_optional
//   R channel : rvalid, rdata, err
// Modports:
//   Manager     -- issues A-channel requests, samples gnt and R-channel.
//   Subordinate -- answers requests with gnt and R-channel responses.
interface OBI_BUS;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        aid;
  logic        a_optional;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport Manager (
    output req, addr, we, be, wdata, aid, a_optional,
    input  gnt, rvalid, rdata, err
  );

  modport Subordinate (
    input  req, addr, we, be, wdata, aid, a_optional,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/ndma_read_mgr.sv
// ndma_read_mgr -- single-outstanding OBI read manager.
// Accepts a consumer read request, issues one OBI read, holds the response
// until the consumer takes it. Back-to-back accept is possible in HOLD.
// Parameters:
//   ERR_RDATA : rdata_o returned with a locally generated error response.
// Ports:
//   clk_i, rst_ni      : clock, synchronous active-low reset
//   req_i, addr_i      : consumer request / byte address
//   acc_o              : request accepted this cycle
//   rvalid_o, rready_i : response handshake to consumer
//   rdata_o, err_o     : response data / error, valid with rvalid_o
//   busy_o             : transaction in flight or data held
//   read_mgr           : OBI_BUS.Manager read port
// Configuration macro:
//   NDMA_RD_MISALIGN_CHK_EN : reject addresses with addr_i[1:0]!=0 locally
//                             with an error response and no bus request.
module ndma_read_mgr #(
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  output logic        acc_o,
  output logic        rvalid_o,
  input  logic        rready_i,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o,
  OBI_BUS.Manager     read_mgr
);

  typedef enum logic [1:0] {IDLE, ADDR, RESP, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q,   err_d;
  logic        accept;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    accept  = 1'b0;

    unique case (state_q)
      IDLE: accept = req_i;
      ADDR: if (read_mgr.gnt) state_d = RESP;
      RESP: begin
        if (read_mgr.rvalid) begin
          rdata_d = read_mgr.rdata;
          err_d   = read_mgr.err;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (rready_i) begin
          accept  = req_i;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new accept (from IDLE or a consumed HOLD) overrides the plain exit.
    if (accept) begin
      addr_d  = addr_i;
      state_d = ADDR;
`ifdef NDMA_RD_MISALIGN_CHK_EN
      if (addr_i[1:0] != 2'b00) begin
        rdata_d = ERR_RDATA;
        err_d   = 1'b1;
        state_d = HOLD;
      end
`endif
    end
  end

  // acc_o is the only output combinational in req_i; mask it while in reset.
  assign acc_o    = accept & rst_ni;
  assign busy_o   = (state_q != IDLE);
  assign rvalid_o = (state_q == HOLD);
  assign rdata_o  = (state_q == HOLD) ? rdata_q : '0;
  assign err_o    = (state_q == HOLD) ? err_q   : 1'b0;

  assign read_mgr.req        = (state_q == ADDR);
  assign read_mgr.addr       = addr_q;
  assign read_mgr.we         = 1'b0;
  assign read_mgr.be         = 4'hF;
  assign read_mgr.wdata      = '0;
  assign read_mgr.aid        = 1'b0;
  assign read_mgr.a_optional = 1'b0;

endmodule

// File: tb/tb_ndma_read_mgr.sv
module tb_ndma_read_mgr;
  localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic [31:0] addr_i;
  logic        acc_o;
  logic        rvalid_o;
  logic        rready_i;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        busy_o;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;

  OBI_BUS bus ();

  ndma_read_mgr #(.ERR_RDATA(ERR_VAL)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req_i),
    .addr_i   (addr_i),
    .acc_o    (acc_o),
    .rvalid_o (rvalid_o),
    .rready_i (rready_i),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .busy_o   (busy_o),
    .read_mgr (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // One transaction from the consumer's view. Expected behaviour follows from
  // the parameters: 1 accept cycle, g+1 address cycles, r+1 response cycles,
  // b+1 hold cycles (the last one with rready_i=1).
  task automatic xfer(input logic [31:0] a, input int unsigned g, input int unsigned r,
                      input int unsigned b, input logic [31:0] d, input logic e,
                      input bit from_idle, input bit chain, input logic [31:0] na);
    bit          mis;
    logic [31:0] exp_d;
    logic        exp_e;
`ifdef NDMA_RD_MISALIGN_CHK_EN
    mis = (a[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    exp_d = mis ? ERR_VAL : d;
    exp_e = mis ? 1'b1 : e;

    if (from_idle) begin
      req_i = 1'b1; addr_i = a; rready_i = 1'b0;
      bus.gnt = 1'b0; bus.rvalid = 1'b0;
      @(negedge clk_i);
      chk("idle_acc", acc_o, 1);
      chk("idle_busy", busy_o, 0);
      chk("idle_bus_req", bus.req, 0);
      chk("idle_rvalid", rvalid_o, 0);
      next_cycle();
    end

    if (!mis) begin
      for (int unsigned k = 0; k <= g; k++) begin
        req_i = $urandom_range(0, 1); addr_i = $urandom; rready_i = $urandom_range(0, 1);
        bus.gnt = (k == g); bus.rvalid = $urandom_range(0, 1); bus.rdata = $urandom; bus.err = 1'b1;
        @(negedge clk_i);
        chk("addr_req", bus.req, 1);
        chk("addr_addr", bus.addr, a);
        chk("addr_we_be", {bus.we, bus.be, bus.aid, bus.a_optional}, 7'b0_1111_00);
        chk("addr_wdata", bus.wdata, 0);
        chk("addr_busy", busy_o, 1);
        chk("addr_acc", acc_o, 0);
        chk("addr_rvalid_o", {rvalid_o, err_o}, 0);
        chk("addr_rdata_o", rdata_o, 0);
        next_cycle();
      end
      bus.gnt = 1'b0;
      for (int unsigned k = 0; k <= r; k++) begin
        req_i = $urandom_range(0, 1); addr_i = $urandom; rready_i = $urandom_range(0, 1);
        bus.rvalid = (k == r);
        bus.rdata  = (k == r) ? d : $urandom;
        bus.err    = (k == r) ? e : 1'b0;
        @(negedge clk_i);
        chk("resp_req", bus.req, 0);
        chk("resp_busy", busy_o, 1);
        chk("resp_acc", acc_o, 0);
        chk("resp_rvalid_o", rvalid_o, 0);
        next_cycle();
      end
    end else begin
      req_i = 1'b0;
    end

    for (int unsigned k = 0; k <= b; k++) begin
      rready_i   = (k == b);
      bus.gnt    = $urandom_range(0, 1);
      bus.rvalid = $urandom_range(0, 1);
      bus.rdata  = $urandom;
      bus.err    = $urandom_range(0, 1);
      req_i      = (k == b) ? chain : 1'($urandom_range(0, 1));
      addr_i     = (k == b && chain) ? na : $urandom;
      @(negedge clk_i);
      chk("hold_rvalid_o", rvalid_o, 1);
      chk("hold_rdata_o", rdata_o, exp_d);
      chk("hold_err_o", err_o, exp_e);
      chk("hold_busy", busy_o, 1);
      chk("hold_bus_req", bus.req, 0);
      chk("hold_acc", acc_o, (k == b && chain));
      next_cycle();
    end
    req_i = 1'b0; rready_i = 1'b0; bus.rvalid = 1'b0; bus.gnt = 1'b0;

    if (!chain) begin
      @(negedge clk_i);
      chk("after_busy", busy_o, 0);
      chk("after_rvalid_o", rvalid_o, 0);
      chk("after_rdata_o", rdata_o, 0);
      chk("after_bus_req", bus.req, 0);
      next_cycle();
    end
  endtask

  initial begin
    logic [31:0] cur_a, nxt_a;
    bit          from_idle, chain;

    rst_ni = 1'b0; req_i = 1'b1; addr_i = 32'h0000_0100; rready_i = 1'b0;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.err = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk_i);
    chk("rst_acc", acc_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_rvalid_o", {rvalid_o, err_o}, 0);
    chk("rst_rdata_o", rdata_o, 0);
    chk("rst_bus_req", bus.req, 0);
    rst_ni = 1'b1; req_i = 1'b0;
    next_cycle();

    // Single read with minimum latency.
    xfer(32'h0000_0100, 0, 0, 0, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, '0);
    // Grant stall over 6 address cycles.
    xfer(32'h0000_0100, 5, 0, 0, 32'h1111_2222, 1'b0, 1'b1, 1'b0, '0);
    // Backpressure for 4 cycles, then back-to-back into 0x104.
    xfer(32'h0000_0100, 0, 1, 4, 32'h3333_4444, 1'b0, 1'b1, 1'b1, 32'h0000_0104);
    xfer(32'h0000_0104, 0, 0, 0, 32'h5555_6666, 1'b0, 1'b0, 1'b0, '0);
    // Bus error response.
    xfer(32'h0000_0200, 1, 2, 1, 32'h1234_5678, 1'b1, 1'b1, 1'b0, '0);
    // Misaligned address: local error with the check, plain pass-through without.
    xfer(32'h0000_0102, 0, 0, 0, 32'h7777_8888, 1'b0, 1'b1, 1'b0, '0);

    // Reset while waiting for the response; the late rvalid must be dropped.
    req_i = 1'b1; addr_i = 32'h0000_0300;
    next_cycle();                       // accepted -> ADDR
    req_i = 1'b0; bus.gnt = 1'b1;
    next_cycle();                       // granted -> RESP
    bus.gnt = 1'b0; rst_ni = 1'b0;
    next_cycle();                       // reset edge
    rst_ni = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'hBAD0_BAD0;
    @(negedge clk_i);
    chk("rst_resp_busy", busy_o, 0);
    chk("rst_resp_rvalid_o", rvalid_o, 0);
    next_cycle();
    bus.rvalid = 1'b0;
    @(negedge clk_i);
    chk("rst_late_rvalid_o", rvalid_o, 0);
    chk("rst_late_rdata_o", rdata_o, 0);
    chk("rst_late_bus_req", bus.req, 0);
    next_cycle();

    // Randomized transactions, some chained back-to-back.
    from_idle = 1'b1;
    cur_a = $urandom;
    for (int i = 0; i < 40; i++) begin
      chain = $urandom_range(0, 1);
      nxt_a = $urandom;
      xfer(cur_a, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom, 1'($urandom_range(0, 1)), from_idle, chain, nxt_a);
      cur_a     = nxt_a;
      from_idle = !chain;
    end
    if (!from_idle)
      xfer(cur_a, 0, 0, 0, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
